// File: rtl/clk_period_meter.sv
// clk_period_meter
// Recovers the period and high time of a slow, asynchronous clock in sysclk
// cycles. The input is synchronised, rising edges delimit measurements, and a
// lock flag plus a sticky loss-of-clock flag summarise the input's health.

module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 1000
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             slowclk_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hcnt;
    logic                   r_armed;

    logic                   w_s;
    logic                   w_rise;
    logic                   w_dead;

    // Counters stick at all-ones so a dead input can never alias a short period.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == LP_CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    assign w_s    = r_sync[SYNC_STAGES-1];
    assign w_rise = w_s & ~r_prev;
    // A rise in the same cycle as the timeout count wins: that is a valid
    // measurement of exactly TIMEOUT cycles, not a lost clock.
    assign w_dead = ~w_rise & (r_cnt == LP_TIMEOUT);

    // Synchroniser chain for the asynchronous input plus the edge-detect flop.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], slowclk_in};
            r_prev <= w_s;
        end
    end

    // Period and high-time counters; each rise closes one period and opens the next.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_hcnt <= '0;
        end else if (w_rise) begin
            r_cnt  <= CNT_W'(1);
            r_hcnt <= CNT_W'(1);
        end else begin
            r_cnt <= sat_inc(r_cnt);
            if (w_s) begin
                r_hcnt <= sat_inc(r_hcnt);
            end
        end
    end

    // Result capture, arming, lock and loss-of-clock status.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            locked    <= 1'b0;
            timeout   <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (w_rise) begin
                timeout <= 1'b0;
                if (r_armed) begin
                    period    <= r_cnt;
                    high_time <= r_hcnt;
                    valid     <= 1'b1;
                    locked    <= 1'b1;
                end else begin
                    // First edge after reset or a timeout is only a reference.
                    r_armed <= 1'b1;
                end
            end else if (w_dead) begin
                timeout <= 1'b1;
                locked  <= 1'b0;
                r_armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter: directed slow-clock waveforms with a
// scoreboard of expected {period, high_time} pairs checked by a monitor.

module tb_clk_period_meter;

    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 300;

    logic             sysclk     = 1'b0;
    logic             rst        = 1'b1;
    logic             slowclk_in = 1'b0;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             valid;
    logic             locked;
    logic             timeout;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          n_valid  = 0;
    int          n_pushed = 0;
    logic [31:0] exp_q[$];
    bit          m_armed  = 1'b0;
    int          cur_h    = 0;
    int          cur_l    = 0;
    int          rise_cyc = 0;
    logic        prev_valid = 1'b0;

    clk_period_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC_STAGES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .sysclk    (sysclk),
        .rst       (rst),
        .slowclk_in(slowclk_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .locked    (locked),
        .timeout   (timeout)
    );

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Start a high phase of h cycles; the rise completes the previous cycle's
    // measurement, so its expected result is queued here if armed.
    task automatic drive_hi(input int h);
        if (m_armed) begin
            exp_q.push_back({16'(cur_h + cur_l), 16'(cur_h)});
            n_pushed++;
        end
        m_armed = 1'b1;
        cur_h   = h;
        @(negedge sysclk);
        slowclk_in = 1'b1;
        rise_cyc   = cyc;
        for (int i = 1; i < h; i++) @(negedge sysclk);
    endtask

    task automatic drive_lo(input int l);
        cur_l = l;
        @(negedge sysclk);
        slowclk_in = 1'b0;
        for (int i = 1; i < l; i++) @(negedge sysclk);
    endtask

    // Monitor: pop and compare on every valid pulse.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge sysclk);
            if (valid) begin
                n_valid++;
                chk("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_valid: got period=%0d high_time=%0d with nothing expected",
                             period, high_time);
                end else begin
                    e = exp_q.pop_front();
                    chk("period", {16'd0, period}, {16'd0, e[31:16]});
                    chk("high_time", {16'd0, high_time}, {16'd0, e[15:0]});
                end
            end
            prev_valid = valid;
        end
    end

    initial begin
        int target;

        // Reset state
        repeat (3) @(negedge sysclk);
        chk("rst_period", {16'd0, period}, 0);
        chk("rst_high_time", {16'd0, high_time}, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_locked", {31'd0, locked}, 0);
        chk("rst_timeout", {31'd0, timeout}, 0);
        rst = 1'b0;

        // Test 1: 51 high / 51 low
        drive_hi(51);
        chk("t1_not_locked_first_rise", {31'd0, locked}, 0);
        drive_lo(51);
        for (int i = 0; i < 3; i++) begin
            drive_hi(51);
            drive_lo(51);
        end
        chk("t1_locked", {31'd0, locked}, 1);

        // Test 2: switch to 30 high / 70 low, then back to 51/51
        drive_hi(30); drive_lo(70);
        drive_hi(30); drive_lo(70);
        drive_hi(51); drive_lo(51);
        drive_hi(51); drive_lo(51);
        chk("t2_period_back", {16'd0, period}, 102);

        // Test 3: stop the clock, expect timeout TIMEOUT cycles after the last rise
        target = rise_cyc + SYNC_STAGES + TIMEOUT;
        while (cyc < target) @(negedge sysclk);
        chk("t3_timeout_not_early", {31'd0, timeout}, 0);
        chk("t3_locked_before", {31'd0, locked}, 1);
        @(negedge sysclk);
        chk("t3_timeout_set", {31'd0, timeout}, 1);
        chk("t3_unlocked", {31'd0, locked}, 0);
        chk("t3_period_hold", {16'd0, period}, 102);
        chk("t3_high_hold", {16'd0, high_time}, 51);
        m_armed = 1'b0;
        repeat (20) @(negedge sysclk);
        chk("t3_timeout_sticky", {31'd0, timeout}, 1);

        // Test 4: restart after timeout
        drive_hi(51);
        chk("t4_timeout_cleared", {31'd0, timeout}, 0);
        chk("t4_not_locked_yet", {31'd0, locked}, 0);
        drive_lo(51);
        drive_hi(51);
        chk("t4_relocked", {31'd0, locked}, 1);

        // Test 5: one-cycle reset between rises while locked
        drive_lo(20);
        rst = 1'b1;
        @(negedge sysclk);
        rst = 1'b0;
        m_armed = 1'b0;
        chk("t5_period_zero", {16'd0, period}, 0);
        chk("t5_high_zero", {16'd0, high_time}, 0);
        chk("t5_valid_zero", {31'd0, valid}, 0);
        chk("t5_locked_zero", {31'd0, locked}, 0);
        chk("t5_timeout_zero", {31'd0, timeout}, 0);
        drive_lo(30);
        drive_hi(51);
        chk("t5_armed_not_locked", {31'd0, locked}, 0);
        drive_lo(51);
        drive_hi(51);
        chk("t5_locked_again", {31'd0, locked}, 1);
        drive_lo(51);

        // Test 6: minimum period of 2, then a period of exactly TIMEOUT
        for (int i = 0; i < 8; i++) begin
            drive_hi(1);
            drive_lo(1);
        end
        drive_hi(1);
        drive_lo(TIMEOUT - 1);
        drive_hi(1);
        drive_lo(10);
        chk("t6_no_timeout", {31'd0, timeout}, 0);
        chk("t6_locked", {31'd0, locked}, 1);
        chk("t6_period_timeout", {16'd0, period}, TIMEOUT);

        repeat (10) @(negedge sysclk);
        chk("queue_drained", exp_q.size(), 0);
        chk("valid_count", n_valid, n_pushed);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
